// File: rtl/ld_req_noc2_issue_queue.sv
// ld_req_noc2_issue_queue
// Buffers load requests in a DEPTH-entry FIFO, tags each one with the
// lowest free local MSHR id, and issues it as a NoC2 load (req_type 60)
// through a single registered output stage. Ids stay busy from issue-register
// load until the matching response frees them.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   ld_valid_i/ready_o  load request handshake (ld_addr_i, ld_size_i)
//   noc2_*              NoC2 request handshake and payload (registered)
//   resp_valid_i        response returned; frees resp_mshrid_i
//   outstanding_o       number of busy ids (registered popcount)
//   err_o               sticky flag: free of an out-of-range or idle id
module ld_req_noc2_issue_queue #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned NUM_MSHR  = 4,
    parameter int unsigned ADDR_W    = 40,
    parameter int unsigned SIZE_W    = 3,
    parameter int unsigned MSHRID_W  = 8,
    parameter int unsigned HOMEID_W  = 30,
    parameter int unsigned HOME_LSB  = 6,
    parameter int unsigned HOME_BITS = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ld_valid_i,
    output logic                          ld_ready_o,
    input  logic [ADDR_W-1:0]             ld_addr_i,
    input  logic [SIZE_W-1:0]             ld_size_i,
    output logic                          noc2_valid_o,
    input  logic                          noc2_ready_i,
    output logic [5:0]                    noc2_req_type_o,
    output logic [MSHRID_W-1:0]           noc2_mshrid_o,
    output logic [ADDR_W-1:0]             noc2_address_o,
    output logic [SIZE_W-1:0]             noc2_size_o,
    output logic [HOMEID_W-1:0]           noc2_homeid_o,
    output logic [7:0]                    noc2_write_mask_o,
    output logic [63:0]                   noc2_data_0_o,
    output logic [63:0]                   noc2_data_1_o,
    input  logic                          resp_valid_i,
    input  logic [MSHRID_W-1:0]           resp_mshrid_i,
    output logic [$clog2(NUM_MSHR+1)-1:0] outstanding_o,
    output logic                          err_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(NUM_MSHR + 1);

    logic [ADDR_W-1:0]   fifo_addr [DEPTH];
    logic [SIZE_W-1:0]   fifo_size [DEPTH];
    logic [PTR_W:0]      wr_ptr;
    logic [PTR_W:0]      rd_ptr;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push;
    logic                load;

    logic [NUM_MSHR-1:0] busy;
    logic [NUM_MSHR-1:0] busy_next;
    logic [NUM_MSHR-1:0] alloc_mask;
    logic [NUM_MSHR-1:0] free_mask;
    logic [MSHRID_W-1:0] alloc_id;
    logic                any_free;
    logic                free_illegal;
    logic [CNT_W-1:0]    cnt_next;

    logic                out_valid;
    logic [ADDR_W-1:0]   out_addr;
    logic [SIZE_W-1:0]   out_size;
    logic [MSHRID_W-1:0] out_id;

    // Extra wrap bit distinguishes full from empty when indices match.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]) &&
                        (wr_ptr[PTR_W] != rd_ptr[PTR_W]);
    assign ld_ready_o = !fifo_full;
    assign push       = ld_valid_i && !fifo_full;
    assign any_free   = |(~busy);
    assign load       = !fifo_empty && any_free && (!out_valid || noc2_ready_i);

    // Lowest-index free id.
    always_comb begin
        logic found;
        found      = 1'b0;
        alloc_mask = '0;
        alloc_id   = '0;
        for (int unsigned i = 0; i < NUM_MSHR; i++) begin
            if (!busy[i] && !found) begin
                found         = 1'b1;
                alloc_mask[i] = 1'b1;
                alloc_id      = MSHRID_W'(i);
            end
        end
    end

    // A free is legal only if it hits an in-range busy id; anything else
    // leaves the bitmap alone and flags an error.
    always_comb begin
        free_mask = '0;
        for (int unsigned i = 0; i < NUM_MSHR; i++) begin
            if (resp_valid_i && (resp_mshrid_i == MSHRID_W'(i)) && busy[i]) begin
                free_mask[i] = 1'b1;
            end
        end
        free_illegal = resp_valid_i && (free_mask == '0);
    end

    // Allocation uses the pre-free bitmap, so a freed id can never be
    // reallocated on the edge that frees it.
    always_comb begin
        busy_next = (busy & ~free_mask) | (load ? alloc_mask : '0);
        cnt_next  = '0;
        for (int unsigned i = 0; i < NUM_MSHR; i++) begin
            cnt_next = cnt_next + CNT_W'(busy_next[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr[PTR_W-1:0]] <= ld_addr_i;
            fifo_size[wr_ptr[PTR_W-1:0]] <= ld_size_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            busy          <= '0;
            outstanding_o <= '0;
            err_o         <= 1'b0;
            out_valid     <= 1'b0;
            out_addr      <= '0;
            out_size      <= '0;
            out_id        <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (load) begin
                rd_ptr    <= rd_ptr + 1'b1;
                out_valid <= 1'b1;
                out_addr  <= fifo_addr[rd_ptr[PTR_W-1:0]];
                out_size  <= fifo_size[rd_ptr[PTR_W-1:0]];
                out_id    <= alloc_id;
            end else if (noc2_ready_i) begin
                out_valid <= 1'b0;
            end
            busy          <= busy_next;
            outstanding_o <= cnt_next;
            if (free_illegal) begin
                err_o <= 1'b1;
            end
        end
    end

    assign noc2_valid_o      = out_valid;
    assign noc2_req_type_o   = 6'd60;
    assign noc2_mshrid_o     = out_id;
    assign noc2_address_o    = out_addr;
    assign noc2_size_o       = out_size;
    assign noc2_homeid_o     = HOMEID_W'(out_addr[HOME_LSB +: HOME_BITS]);
    assign noc2_write_mask_o = '0;
    assign noc2_data_0_o     = '0;
    assign noc2_data_1_o     = '0;

endmodule

// File: tb/tb_ld_req_noc2_issue_queue.sv
// Directed self-checking bench for ld_req_noc2_issue_queue with default
// parameters (DEPTH=4, NUM_MSHR=4). Inputs change and outputs are sampled
// 1 ns after each rising edge.
module tb_ld_req_noc2_issue_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ld_valid;
    logic        ld_ready;
    logic [39:0] ld_addr;
    logic [2:0]  ld_size;
    logic        noc2_valid;
    logic        noc2_ready;
    logic [5:0]  noc2_req_type;
    logic [7:0]  noc2_mshrid;
    logic [39:0] noc2_address;
    logic [2:0]  noc2_size;
    logic [29:0] noc2_homeid;
    logic [7:0]  noc2_write_mask;
    logic [63:0] noc2_data_0;
    logic [63:0] noc2_data_1;
    logic        resp_valid;
    logic [7:0]  resp_mshrid;
    logic [2:0]  outstanding;
    logic        err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ld_req_noc2_issue_queue #(
        .DEPTH(4), .NUM_MSHR(4), .ADDR_W(40), .SIZE_W(3),
        .MSHRID_W(8), .HOMEID_W(30), .HOME_LSB(6), .HOME_BITS(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ld_valid_i(ld_valid), .ld_ready_o(ld_ready),
        .ld_addr_i(ld_addr), .ld_size_i(ld_size),
        .noc2_valid_o(noc2_valid), .noc2_ready_i(noc2_ready),
        .noc2_req_type_o(noc2_req_type), .noc2_mshrid_o(noc2_mshrid),
        .noc2_address_o(noc2_address), .noc2_size_o(noc2_size),
        .noc2_homeid_o(noc2_homeid), .noc2_write_mask_o(noc2_write_mask),
        .noc2_data_0_o(noc2_data_0), .noc2_data_1_o(noc2_data_1),
        .resp_valid_i(resp_valid), .resp_mshrid_i(resp_mshrid),
        .outstanding_o(outstanding), .err_o(err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        ld_valid    = 1'b0;
        ld_addr     = '0;
        ld_size     = '0;
        noc2_ready  = 1'b0;
        resp_valid  = 1'b0;
        resp_mshrid = '0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({ld_ready, noc2_valid, outstanding, err} !== {1'b1, 1'b0, 3'd0, 1'b0}) begin
            failures++;
            $display("FAIL reset_ctrl: ready=%0b valid=%0b outstanding=%0d err=%0b, want 1 0 0 0",
                     ld_ready, noc2_valid, outstanding, err);
        end
        checks++;
        if (noc2_req_type !== 6'd60) begin
            failures++;
            $display("FAIL reset_req_type: got %0d want 60", noc2_req_type);
        end
        checks++;
        if ({noc2_mshrid, noc2_address, noc2_size, noc2_homeid, noc2_write_mask, noc2_data_0, noc2_data_1} !== '0) begin
            failures++;
            $display("FAIL reset_payload: id=%0h addr=%0h size=%0h home=%0h, want all 0",
                     noc2_mshrid, noc2_address, noc2_size, noc2_homeid);
        end
    endtask

    task automatic test_single();
        do_reset();
        noc2_ready = 1'b1;
        ld_valid   = 1'b1;
        ld_addr    = 40'h00_0000_1040;
        ld_size    = 3'd3;
        step();                       // accept edge N
        ld_valid = 1'b0;
        checks++;
        if (noc2_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_latency1: valid=%0b want 0", noc2_valid);
        end
        step();                       // edge N+1: issue register loaded
        checks++;
        if ({noc2_valid, noc2_mshrid, noc2_homeid, noc2_req_type, noc2_size, noc2_address, outstanding} !==
            {1'b1, 8'd0, 30'd1, 6'd60, 3'd3, 40'h00_0000_1040, 3'd1}) begin
            failures++;
            $display("FAIL single_issue: valid=%0b id=%0d home=%0d type=%0d size=%0d addr=%0h out=%0d, want 1 0 1 60 3 1040 1",
                     noc2_valid, noc2_mshrid, noc2_homeid, noc2_req_type, noc2_size, noc2_address, outstanding);
        end
        step();                       // handshake completes
        checks++;
        if ({noc2_valid, outstanding} !== {1'b0, 3'd1}) begin
            failures++;
            $display("FAIL single_after_hs: valid=%0b out=%0d, want 0 1", noc2_valid, outstanding);
        end
        resp_valid  = 1'b1;
        resp_mshrid = 8'd0;
        step();
        resp_valid = 1'b0;
        checks++;
        if ({outstanding, err} !== {3'd0, 1'b0}) begin
            failures++;
            $display("FAIL single_free: out=%0d err=%0b, want 0 0", outstanding, err);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        ld_valid = 1'b1;
        ld_addr  = 40'hAB_CDEF_0123;
        ld_size  = 3'd5;
        step();
        ld_valid = 1'b0;
        ld_addr  = '0;
        step();
        for (int c = 0; c < 5; c++) begin
            checks++;
            if ({noc2_valid, noc2_address, noc2_size, noc2_mshrid, noc2_homeid} !==
                {1'b1, 40'hAB_CDEF_0123, 3'd5, 8'd0, 30'd4}) begin
                failures++;
                $display("FAIL backpressure_hold[%0d]: valid=%0b addr=%0h size=%0d id=%0d home=%0d, want 1 abcdef0123 5 0 4",
                         c, noc2_valid, noc2_address, noc2_size, noc2_mshrid, noc2_homeid);
            end
            if (c < 4) step();
        end
        noc2_ready = 1'b1;
        step();
        checks++;
        if (noc2_valid !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_release: valid=%0b want 0", noc2_valid);
        end
        noc2_ready = 1'b0;
    endtask

    task automatic test_pool_exhaustion();
        do_reset();
        noc2_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            ld_valid = 1'b1;
            ld_addr  = 40'(k) << 6;
            ld_size  = 3'd1;
            step();
            checks++;
            if (k >= 1 && k <= 4) begin
                if ({noc2_valid, noc2_mshrid, noc2_address} !== {1'b1, 8'(k - 1), 40'(k - 1) << 6}) begin
                    failures++;
                    $display("FAIL pool_issue[%0d]: valid=%0b id=%0d addr=%0h, want 1 %0d %0h",
                             k, noc2_valid, noc2_mshrid, noc2_address, k - 1, (k - 1) << 6);
                end
            end else if (noc2_valid !== 1'b0) begin
                failures++;
                $display("FAIL pool_idle[%0d]: valid=%0b want 0", k, noc2_valid);
            end
        end
        ld_valid = 1'b0;
        step();
        checks++;
        if ({noc2_valid, outstanding, ld_ready} !== {1'b0, 3'd4, 1'b1}) begin
            failures++;
            $display("FAIL pool_exhausted: valid=%0b out=%0d ready=%0b, want 0 4 1", noc2_valid, outstanding, ld_ready);
        end
        resp_valid  = 1'b1;
        resp_mshrid = 8'd2;
        step();
        resp_valid = 1'b0;
        checks++;
        if ({noc2_valid, outstanding} !== {1'b0, 3'd3}) begin
            failures++;
            $display("FAIL pool_freed: valid=%0b out=%0d, want 0 3", noc2_valid, outstanding);
        end
        step();
        checks++;
        if ({noc2_valid, noc2_mshrid, noc2_address, outstanding} !== {1'b1, 8'd2, 40'h100, 3'd4}) begin
            failures++;
            $display("FAIL pool_reissue: valid=%0b id=%0d addr=%0h out=%0d, want 1 2 100 4",
                     noc2_valid, noc2_mshrid, noc2_address, outstanding);
        end
    endtask

    task automatic test_fifo_full();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (ld_ready !== 1'b1) begin
                failures++;
                $display("FAIL fifo_ready_before[%0d]: ready=%0b want 1", k, ld_ready);
            end
            ld_valid = 1'b1;
            ld_addr  = 40'h10_0000_0000 | (40'(k) << 6);
            step();
        end
        checks++;
        if (ld_ready !== 1'b0) begin
            failures++;
            $display("FAIL fifo_full: ready=%0b want 0", ld_ready);
        end
        ld_addr = 40'h10_0000_0140;   // sixth request waits
        step();
        step();
        checks++;
        if ({ld_ready, noc2_valid, noc2_mshrid, noc2_address} !== {1'b0, 1'b1, 8'd0, 40'h10_0000_0000}) begin
            failures++;
            $display("FAIL fifo_stall: ready=%0b valid=%0b id=%0d addr=%0h, want 0 1 0 1000000000",
                     ld_ready, noc2_valid, noc2_mshrid, noc2_address);
        end
        noc2_ready = 1'b1;
        step();                       // handshake + pop of req1
        noc2_ready = 1'b0;
        checks++;
        if ({ld_ready, noc2_valid, noc2_mshrid, noc2_address} !== {1'b1, 1'b1, 8'd1, 40'h10_0000_0040}) begin
            failures++;
            $display("FAIL fifo_pop: ready=%0b valid=%0b id=%0d addr=%0h, want 1 1 1 1000000040",
                     ld_ready, noc2_valid, noc2_mshrid, noc2_address);
        end
        step();                       // sixth request accepted
        ld_valid = 1'b0;
        checks++;
        if ({ld_ready, noc2_mshrid} !== {1'b0, 8'd1}) begin
            failures++;
            $display("FAIL fifo_sixth: ready=%0b id=%0d, want 0 1", ld_ready, noc2_mshrid);
        end
    endtask

    task automatic test_simul_free_alloc();
        do_reset();
        noc2_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            ld_valid = 1'b1;
            ld_addr  = 40'h200 + (40'(k) << 6);
            step();
        end
        ld_valid = 1'b0;
        step();
        checks++;
        if ({noc2_valid, outstanding} !== {1'b0, 3'd4}) begin
            failures++;
            $display("FAIL sfa_full: valid=%0b out=%0d, want 0 4", noc2_valid, outstanding);
        end
        resp_valid  = 1'b1;
        resp_mshrid = 8'd1;
        step();
        resp_valid = 1'b0;
        checks++;
        if ({noc2_valid, outstanding} !== {1'b0, 3'd3}) begin
            failures++;
            $display("FAIL sfa_free_edge: valid=%0b out=%0d, want 0 3", noc2_valid, outstanding);
        end
        step();
        checks++;
        if ({noc2_valid, noc2_mshrid, noc2_address, outstanding} !== {1'b1, 8'd1, 40'h300, 3'd4}) begin
            failures++;
            $display("FAIL sfa_alloc: valid=%0b id=%0d addr=%0h out=%0d, want 1 1 300 4",
                     noc2_valid, noc2_mshrid, noc2_address, outstanding);
        end
    endtask

    task automatic test_illegal_free();
        do_reset();
        noc2_ready = 1'b1;
        ld_valid   = 1'b1;
        ld_addr    = 40'h0;
        step();
        ld_valid = 1'b0;
        step();
        step();
        resp_valid  = 1'b1;
        resp_mshrid = 8'd7;
        step();
        checks++;
        if ({err, outstanding} !== {1'b1, 3'd1}) begin
            failures++;
            $display("FAIL illegal_range: err=%0b out=%0d, want 1 1", err, outstanding);
        end
        resp_mshrid = 8'd0;           // legal free of busy id 0
        step();
        checks++;
        if ({err, outstanding} !== {1'b1, 3'd0}) begin
            failures++;
            $display("FAIL illegal_sticky: err=%0b out=%0d, want 1 0", err, outstanding);
        end
        step();                       // id 0 is now idle: illegal
        resp_valid = 1'b0;
        checks++;
        if ({err, outstanding} !== {1'b1, 3'd0}) begin
            failures++;
            $display("FAIL illegal_idle: err=%0b out=%0d, want 1 0", err, outstanding);
        end
        do_reset();
        checks++;
        if ({err, outstanding, ld_ready, noc2_valid} !== {1'b0, 3'd0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL illegal_reset: err=%0b out=%0d ready=%0b valid=%0b, want 0 0 1 0",
                     err, outstanding, ld_ready, noc2_valid);
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        ld_valid = 1'b1;
        ld_addr  = 40'h440;
        step();
        ld_valid = 1'b0;
        step();                       // id 0 now busy, request in output register
        do_reset();
        checks++;
        if ({noc2_valid, outstanding, err} !== {1'b0, 3'd0, 1'b0}) begin
            failures++;
            $display("FAIL midreset_clear: valid=%0b out=%0d err=%0b, want 0 0 0", noc2_valid, outstanding, err);
        end
        resp_valid  = 1'b1;
        resp_mshrid = 8'd0;
        step();
        resp_valid = 1'b0;
        checks++;
        if ({err, outstanding} !== {1'b1, 3'd0}) begin
            failures++;
            $display("FAIL midreset_stale_free: err=%0b out=%0d, want 1 0", err, outstanding);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_pool_exhaustion();
        test_fifo_full();
        test_simul_free_alloc();
        test_illegal_free();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ld_req_noc2_issue_queue.md
Name: ld_req_noc2_issue_queue

Overview:
- Parametrised successor to the single-shot load-request-to-NoC2 adapter inside the fifo_controller load unit.
- Buffers load requests in a DEPTH-entry FIFO and allocates a local MSHR id from a pool of NUM_MSHR ids.
- Issues each request as a NoC2 load (req_type 60) with a homeid derived from the address.
- Supports up to NUM_MSHR requests in flight. Ids are freed when the NoC response returns.

Parameters:
- DEPTH, 4: request FIFO entries; power of 2, >=2.
- NUM_MSHR, 4: outstanding-id pool size; 1..2**MSHRID_W.
- ADDR_W, 40: physical address width.
- SIZE_W, 3: request size field width.
- MSHRID_W, 8: NoC2 mshrid field width.
- HOMEID_W, 30: NoC2 homeid field width.
- HOME_LSB, 6: lowest address bit used for homeid.
- HOME_BITS, 4: number of address bits used for homeid; HOME_BITS <= HOMEID_W.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- ld_valid_i  in  1  load request valid
- ld_ready_o  out  1  FIFO can accept
- ld_addr_i  in  ADDR_W  request address
- ld_size_i  in  SIZE_W  request size
- noc2_valid_o  out  1  NoC2 request valid
- noc2_ready_i  in  1  NoC2 accepts
- noc2_req_type_o  out  6  constant 6'd60
- noc2_mshrid_o  out  MSHRID_W  allocated id, zero-extended
- noc2_address_o  out  ADDR_W  request address
- noc2_size_o  out  SIZE_W  request size
- noc2_homeid_o  out  HOMEID_W  addr[HOME_LSB +: HOME_BITS], zero-extended
- noc2_write_mask_o  out  8  constant 0
- noc2_data_0_o  out  64  constant 0
- noc2_data_1_o  out  64  constant 0
- resp_valid_i  in  1  response returned, frees its id
- resp_mshrid_i  in  MSHRID_W  id being freed
- outstanding_o  out  clog2(NUM_MSHR+1)  count of busy ids
- err_o  out  1  sticky: illegal free seen

Behaviour:
- Reset: rst_n is synchronous, active-low; clock is clk.
  - FIFO empty; all ids free; output register invalid.
  - ld_ready_o=1; noc2_valid_o=0; outstanding_o=0; err_o=0.
  - Datapath outputs are 0, except req_type, which stays 60.
  - Reset mid-operation discards queued and in-flight state. Responses arriving after reset for pre-reset ids are treated as illegal frees.
- Enqueue:
  - ld_ready_o = !fifo_full.
  - A push occurs when ld_valid_i && ld_ready_o.
  - Pointers carry an extra wrap bit. Full when the indices are equal and the wrap bits differ.
  - ld_ready_o does not depend combinationally on ld_valid_i.
- Issue stage: one output register.
  - load = fifo_nonempty && any_free && (!noc2_valid_o || noc2_ready_i).
  - On load: pop the FIFO head into the register, allocate the lowest-index free id, and mark that id busy in the same edge.
  - Minimum latency: request accepted at edge N appears as noc2_valid_o=1 after edge N+1 (2 cycles).
  - Back-to-back: one issue per cycle while noc2_ready_i=1 and ids are available.
- NoC2 handshake:
  - Once noc2_valid_o=1, it and all payload fields are held stable until noc2_ready_i=1.
  - noc2_valid_o never depends combinationally on noc2_ready_i.
- Pool exhausted: with all NUM_MSHR ids busy, the FIFO head waits. The FIFO keeps accepting until full.
- Free:
  - On resp_valid_i with an id that is in range and busy: clear the busy bit at that edge.
  - An id freed at edge N is allocatable from edge N+1. Allocation at edge N sees the pre-free bitmap.
  - Freeing and allocating different ids in the same cycle leaves outstanding_o unchanged.
- Illegal free: resp_mshrid_i >= NUM_MSHR, or the id is not busy.
  - The bitmap is unchanged.
  - err_o sets and stays 1 until reset.
- outstanding_o equals the popcount of the busy bitmap, registered and updated every edge.
- Id accounting: an id counts as busy from allocation (issue-register load), not from the NoC2 handshake.

Test Plan:
- Single request: addr 0x00_0000_1040, size 3, ready held 1 -> noc2_valid_o rises 2 cycles after accept; mshrid 0; homeid 1; req_type 60; outstanding_o 1.
- Backpressure: ready=0 for 5 cycles after valid -> all payload fields stable for all 5 cycles; handshake completes in the cycle ready=1.
- Pool exhaustion (NUM_MSHR=4): 6 back-to-back requests, no responses -> ids 0,1,2,3 issued; valid then drops; FIFO holds 2. Free id 2 -> next request issues with id 2 one cycle later.
- FIFO full (DEPTH=4): noc2_ready_i=0, push 5 requests -> ld_ready_o=0 after the 5th accept (4 queued + 1 in the output register); 6th request stalls until a pop.
- Simultaneous free+alloc: pool full, free id 1 while a request waits -> no allocation that edge; id 1 issued next edge; outstanding_o shows 4 -> 3 -> 4.
- Illegal free: resp_mshrid 7 (NUM_MSHR=4), then free of an idle id 0 -> err_o=1 and stays set; bitmap and outstanding_o unchanged; rst_n low for 1 cycle clears err_o and all state.
